// File: rtl/mdio_cmd_rx.sv
// Snoops the TRN RX stream for single-DW BAR0 memory writes to the MDIO command register.
// Byte-swaps the payload into a one-entry valid/ready buffer; MDIO_CMD_RX_MWR64_EN adds MWr64 decode.
module mdio_cmd_rx #(
    parameter logic [3:0] CMD_DW_OFFSET = 4'h4,
    parameter int         CNT_W         = 8
) (
    input  logic             trn_clk,
    input  logic             reset,
    input  logic [63:0]      trn_rd,
    input  logic [7:0]       trn_rrem_n,
    input  logic             trn_rsof_n,
    input  logic             trn_reof_n,
    input  logic             trn_rsrc_rdy_n,
    input  logic             trn_rsrc_dsc_n,
    input  logic [6:0]       trn_rbar_hit_n,
    input  logic             trn_rdst_rdy_n,
    output logic             cmd_valid,
    output logic [31:0]      cmd_data,
    input  logic             cmd_ready,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR32 = 3'd1,
`ifdef MDIO_CMD_RX_MWR64_EN
        ST_ADDR64 = 3'd2,
        ST_DATA64 = 3'd3,
`endif
        ST_DRAIN  = 3'd4
    } state_e;

    localparam logic [6:0] FMT_MWR32 = 7'b10_00000;
    localparam logic [6:0] FMT_MWR64 = 7'b11_00000;

    state_e           state_q;
    logic             cmd_valid_q;
    logic [31:0]      cmd_data_q;
    logic [CNT_W-1:0] drop_cnt_q;
`ifdef MDIO_CMD_RX_MWR64_EN
    logic             hit64_q;
`endif

    logic        beat;
    logic        sof_beat;
    logic        len_one;
    logic        commit;
    logic [31:0] commit_dw;
    logic [31:0] cmd_data_d;
    logic        unused_ok;

    assign beat      = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
    assign sof_beat  = beat && !trn_rsof_n;
    assign len_one   = (trn_rd[41:32] == 10'd1);
    assign unused_ok = ^{trn_rrem_n, trn_rbar_hit_n[6:1], trn_rd[63], trn_rd[55:42]};

    // Only an EOF beat that is not discontinued can deliver the payload DW.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        commit    = 1'b0;
        commit_dw = '0;
        if (beat && trn_rsrc_dsc_n && !trn_reof_n) begin
            case (state_q)
                ST_ADDR32: begin
                    commit    = (trn_rd[37:34] == CMD_DW_OFFSET);
                    commit_dw = trn_rd[31:0];
                end
`ifdef MDIO_CMD_RX_MWR64_EN
                ST_DATA64: begin
                    commit    = hit64_q;
                    commit_dw = trn_rd[63:32];
                end
`endif
                default: ;
            endcase
        end
        cmd_data_d = {commit_dw[7:0], commit_dw[15:8], commit_dw[23:16], commit_dw[31:24]};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_data_q  <= '0;
            drop_cnt_q  <= '0;
`ifdef MDIO_CMD_RX_MWR64_EN
            hit64_q     <= 1'b0;
`endif
        end else begin
            if (state_q != ST_IDLE && !trn_rsrc_dsc_n) begin
                state_q <= ST_IDLE;
            end else if (beat) begin
                case (state_q)
                    ST_IDLE: begin
                        if (sof_beat) begin
                            if (!trn_rbar_hit_n[0] && trn_rd[62:56] == FMT_MWR32 && len_one)
                                state_q <= ST_ADDR32;
`ifdef MDIO_CMD_RX_MWR64_EN
                            else if (!trn_rbar_hit_n[0] && trn_rd[62:56] == FMT_MWR64 && len_one)
                                state_q <= ST_ADDR64;
`endif
                            else if (trn_reof_n)
                                state_q <= ST_DRAIN;
                        end
                    end
                    ST_ADDR32: state_q <= trn_reof_n ? ST_DRAIN : ST_IDLE;
`ifdef MDIO_CMD_RX_MWR64_EN
                    ST_ADDR64: begin
                        hit64_q <= (trn_rd[5:2] == CMD_DW_OFFSET);
                        state_q <= ST_DATA64;
                    end
                    ST_DATA64: state_q <= trn_reof_n ? ST_DRAIN : ST_IDLE;
`endif
                    ST_DRAIN: begin
                        if (!trn_reof_n)
                            state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end

            // A commit during a handshake refills the buffer without a bubble.
            if (commit) begin
                if (!cmd_valid_q || cmd_ready) begin
                    cmd_valid_q <= 1'b1;
                    cmd_data_q  <= cmd_data_d;
                end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
                    drop_cnt_q <= drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else if (cmd_valid_q && cmd_ready) begin
                cmd_valid_q <= 1'b0;
            end
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_data  = cmd_data_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mdio_cmd_rx.sv
// Scoreboard bench for mdio_cmd_rx: stimulus pushes expected command words, a monitor pops them on handshakes.
// Honours MDIO_CMD_RX_MWR64_EN to choose the expected MWr64 outcome.
module tb_mdio_cmd_rx;

    logic        trn_clk = 1'b0;
    logic        reset;
    logic [63:0] trn_rd;
    logic [7:0]  trn_rrem_n;
    logic        trn_rsof_n;
    logic        trn_reof_n;
    logic        trn_rsrc_rdy_n;
    logic        trn_rsrc_dsc_n;
    logic [6:0]  trn_rbar_hit_n;
    logic        trn_rdst_rdy_n;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic [7:0]  drop_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    mdio_cmd_rx #(.CMD_DW_OFFSET(4'h4), .CNT_W(8)) dut (
        .trn_clk        (trn_clk),
        .reset          (reset),
        .trn_rd         (trn_rd),
        .trn_rrem_n     (trn_rrem_n),
        .trn_rsof_n     (trn_rsof_n),
        .trn_reof_n     (trn_reof_n),
        .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n (trn_rsrc_dsc_n),
        .trn_rbar_hit_n (trn_rbar_hit_n),
        .trn_rdst_rdy_n (trn_rdst_rdy_n),
        .cmd_valid      (cmd_valid),
        .cmd_data       (cmd_data),
        .cmd_ready      (cmd_ready),
        .drop_cnt       (drop_cnt)
    );

    always #5 trn_clk = ~trn_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next edge.
    always @(negedge trn_clk) begin
        if (!reset && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %h expected no command", cmd_data);
            end else begin
                check("sb_data", cmd_data, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_bus();
        trn_rd         = '0;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
    endtask

    task automatic drive(input bit sof, input bit eof, input bit dsc, input logic [63:0] d);
        trn_rd         = d;
        trn_rsof_n     = !sof;
        trn_reof_n     = !eof;
        trn_rsrc_dsc_n = !dsc;
        trn_rsrc_rdy_n = 1'b0;
        @(posedge trn_clk);
        #1;
        idle_bus();
    endtask

    task automatic mwr32(input logic [31:0] addr, input logic [31:0] data, input bit dsc);
        drive(1'b1, 1'b0, 1'b0, 64'h4000_0001_0000_000F);
        drive(1'b0, 1'b1, dsc, {addr, data});
    endtask

    task automatic ready_pulse();
        cmd_ready = 1'b1;
        @(posedge trn_clk);
        #1;
        cmd_ready = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge trn_clk);
        #1;
    endtask

    initial begin
        idle_bus();
        reset          = 1'b1;
        trn_rrem_n     = 8'h00;
        trn_rbar_hit_n = 7'b111_1110;
        trn_rdst_rdy_n = 1'b0;
        cmd_ready      = 1'b0;
        wait_cycles(3);
        reset = 1'b0;
        check("reset_valid", {31'd0, cmd_valid}, 32'd0);
        check("reset_data", cmd_data, 32'd0);
        check("reset_drop", {24'd0, drop_cnt}, 32'd0);

        // Matching write, held until ready.
        sb.push_back(32'h4433_2211);
        mwr32(32'h0000_0010, 32'h1122_3344, 1'b0);
        check("basic_valid", {31'd0, cmd_valid}, 32'd1);
        check("basic_data", cmd_data, 32'h4433_2211);
        wait_cycles(4);
        check("basic_hold_valid", {31'd0, cmd_valid}, 32'd1);
        check("basic_hold_data", cmd_data, 32'h4433_2211);
        ready_pulse();
        check("basic_clear", {31'd0, cmd_valid}, 32'd0);

        // Wrong offset and wrong BAR: no commit.
        mwr32(32'h0000_000C, 32'hDEAD_BEEF, 1'b0);
        wait_cycles(2);
        check("offset_valid", {31'd0, cmd_valid}, 32'd0);
        check("offset_drop", {24'd0, drop_cnt}, 32'd0);
        trn_rbar_hit_n = 7'b111_1101;
        mwr32(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        trn_rbar_hit_n = 7'b111_1110;
        wait_cycles(2);
        check("bar1_valid", {31'd0, cmd_valid}, 32'd0);

        // Back-to-back with ready low: second dropped.
        sb.push_back(32'h0403_0201);
        mwr32(32'h0000_0010, 32'h0102_0304, 1'b0);
        mwr32(32'h0000_0010, 32'h0506_0708, 1'b0);
        check("b2b_data", cmd_data, 32'h0403_0201);
        check("b2b_drop", {24'd0, drop_cnt}, 32'd1);

        // EOF beat coincides with a handshake: old popped, new loaded, no bubble.
        sb.push_back(32'hDDCC_BBAA);
        drive(1'b1, 1'b0, 1'b0, 64'h4000_0001_0000_000F);
        cmd_ready = 1'b1;
        drive(1'b0, 1'b1, 1'b0, {32'h0000_0010, 32'hAABB_CCDD});
        cmd_ready = 1'b0;
        check("nobubble_valid", {31'd0, cmd_valid}, 32'd1);
        check("nobubble_data", cmd_data, 32'hDDCC_BBAA);
        check("nobubble_drop", {24'd0, drop_cnt}, 32'd1);
        ready_pulse();
        check("nobubble_clear", {31'd0, cmd_valid}, 32'd0);

        // Saturation: 300 drops on top of 1.
        sb.push_back(32'h7856_3412);
        mwr32(32'h0000_0010, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 300; i++) mwr32(32'h0000_0010, i, 1'b0);
        check("sat_drop", {24'd0, drop_cnt}, 32'd255);
        check("sat_data", cmd_data, 32'h7856_3412);
        ready_pulse();

        // Discontinue on the data beat.
        mwr32(32'h0000_0010, 32'hCAFE_F00D, 1'b1);
        wait_cycles(2);
        check("dsc_valid", {31'd0, cmd_valid}, 32'd0);

        // Reset between SOF and EOF; trailing body must be ignored.
        drive(1'b1, 1'b0, 1'b0, 64'h4000_0001_0000_000F);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, {32'h0000_0010, 32'hCAFE_F00D});
        wait_cycles(2);
        check("rst_valid", {31'd0, cmd_valid}, 32'd0);
        sb.push_back(32'hEFBE_ADDE);
        mwr32(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        check("recover_data", cmd_data, 32'hEFBE_ADDE);
        ready_pulse();

        // MWr64 single-DW write.
`ifdef MDIO_CMD_RX_MWR64_EN
        sb.push_back(32'hDDCC_BBAA);
`endif
        drive(1'b1, 1'b0, 1'b0, 64'h6000_0001_0000_000F);
        drive(1'b0, 1'b0, 1'b0, 64'h0000_0000_0000_0010);
        drive(1'b0, 1'b1, 1'b0, 64'hAABB_CCDD_0000_0000);
`ifdef MDIO_CMD_RX_MWR64_EN
        check("mwr64_valid", {31'd0, cmd_valid}, 32'd1);
        check("mwr64_data", cmd_data, 32'hDDCC_BBAA);
        ready_pulse();
`else
        check("mwr64_valid", {31'd0, cmd_valid}, 32'd0);
`endif
        sb.push_back(32'h8877_6655);
        mwr32(32'h0000_0010, 32'h5566_7788, 1'b0);
        check("post64_data", cmd_data, 32'h8877_6655);
        ready_pulse();

        wait_cycles(3);
        check("sb_empty", sb.size(), 32'd0);
        check("final_drop", {24'd0, drop_cnt}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
